exec_sequencer: RTL
===================

# exec_sequencer

Multi-cycle control FSM for the RV32E core. It sequences instruction fetch, execute, optional memory access and writeback over valid/ready handshakes, replacing the fixed three-phase free-running counter. It sits beside the PC, register file and control unit. It drives their write enables and holds the current instruction, so every datapath step is gated by actual memory responses rather than a fixed cycle count.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent waiting in any single handshake state before entering ERROR. Legal range 1..65535.
- NOP_INST, 32'h0000_0013: instruction-register value at reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifu_req_valid  out  1  fetch request; the address is the current `pc` from the PC block.
- ifu_req_ready  in  1  instruction memory accepts the request.
- ifu_resp_valid  in  1  instruction data valid.
- ifu_resp_data  in  32  fetched instruction.
- inst  out  32  registered current instruction; feeds the control unit.
- is_mem  in  1  decoded: instruction is a load or store.
- rd_wr  in  1  decoded: instruction writes rd.
- is_ebreak  in  1  decoded: ebreak.
- lsu_req_valid  out  1  data-memory request.
- lsu_req_ready  in  1  data memory accepts the request.
- lsu_resp_valid  in  1  load data available, or store completed.
- rf_wen  out  1  register-file write strobe.
- pc_wen  out  1  PC update strobe.
- halted  out  1  sticky; ebreak retired.
- err  out  1  sticky; handshake timeout.
- instret  out  64  retired-instruction counter.

## Operation
- States: IDLE, FETCH, WAIT_INST, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, ERROR.
- IDLE: entered on reset. Always moves to FETCH on the next edge.
- FETCH: ifu_req_valid=1. When ifu_req_ready=1, move to WAIT_INST.
- WAIT_INST: when ifu_resp_valid=1, latch ifu_resp_data into inst and move to EXEC. Responses arriving in any other state are ignored.
- EXEC: one cycle for the datapath to settle. Priority: is_ebreak → HALT; else is_mem → MEM_REQ; else → WB.
- MEM_REQ: lsu_req_valid=1. When lsu_req_ready=1, move to MEM_WAIT.
- MEM_WAIT: when lsu_resp_valid=1, move to WB.
- WB: pc_wen=1 and rf_wen=rd_wr, both for exactly this cycle. instret increments by 1. Next state is FETCH.
- HALT: asserted when ebreak reaches EXEC.
  - ebreak does not update the PC and is not counted in instret.
  - halted=1; all request and strobe outputs are 0.
  - Only reset exits.
- ERROR: err=1; all request and strobe outputs are 0. Only reset exits.
- Watchdog:
  - A 16-bit counter runs while the FSM is in FETCH, WAIT_INST, MEM_REQ or MEM_WAIT.
  - It clears on every state change.
  - When the count equals TIMEOUT_CYCLES−1 and the exit condition of the current state is false, the next state is ERROR.
  - If the exit condition is true in that same cycle, the normal transition wins.
- instret is 64 bits and wraps from 2^64−1 to 0.
- Decoded inputs (is_mem, rd_wr, is_ebreak) are sampled only in EXEC and WB.

## Timing
- Reset values: state=IDLE, inst=NOP_INST, instret=0, watchdog=0. ifu_req_valid, lsu_req_valid, rf_wen, pc_wen, halted and err are all 0.
- Reset is asynchronous: asserting rst mid-instruction immediately drops every request and strobe. No partial writeback occurs.
- All outputs are Moore outputs: decoded from registered state and registers only, with no combinational input-to-output path.
- Zero-wait memory (ready=1 in the request cycle, response on the following cycle):
  - Non-memory instruction: FETCH, WAIT_INST, EXEC, WB = 4 cycles.
  - Memory instruction: 6 cycles.
- Reset release: the first ifu_req_valid appears 1 cycle after rst deasserts (the IDLE cycle).
- Request-valid handshake: once a request valid is asserted, it stays high until ready is seen. A request is never withdrawn except by reset, or by ERROR on timeout.
- pc_wen and rf_wen never assert in consecutive cycles. At most one retirement happens per 4 cycles.

## Structure
- Shared header defines.v holds:
  - State encoding macros (4-bit: IDLE=0 … ERROR=8).
  - NOP_INST default.
  - Watchdog width.
- One sub-module: seq_watchdog.
  - Inputs: clk, rst, enable, clear, limit.
  - Output: expire.
  - Async reset.
- Everything else lives in exec_sequencer: the state register, next-state logic, inst register and instret.
- Integration into rv32:
  - clk1_flag is replaced by rf_wen.
  - clk2_flag is replaced by pc_wen.
  - The core's inst input is replaced by the ifu_* ports.

## Test plan
- Reset: hold rst 3 cycles, then release → inst=32'h0000_0013, all strobes 0; ifu_req_valid=1 exactly 1 cycle after release.
- Single ALU instruction, zero-wait memory (is_mem=0, rd_wr=1, ifu_resp_data=32'h0010_0093) → rf_wen and pc_wen high in cycle 4, instret=1, then FETCH again.
- Load with waits: ifu_req_ready delayed 2 cycles, lsu_resp_valid delayed 3 cycles, is_mem=1 → total 11 cycles; ifu_req_valid and lsu_req_valid held steady while waiting; one WB pulse.
- Store (is_mem=1, rd_wr=0) → pc_wen=1, rf_wen=0 in WB.
- ebreak (is_ebreak=1) → halted=1 after EXEC; no pc_wen; instret unchanged; stays halted for 100 cycles.
- Timeout with TIMEOUT_CYCLES=8 and ifu_req_ready stuck at 0 → err=1 after 8 cycles in FETCH; ifu_req_valid drops. Separately, rst asserted in MEM_WAIT → outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/exec_sequencer_pkg.sv
// Shared types and constants for the exec_sequencer control FSM and its watchdog.
package exec_sequencer_pkg;

  localparam int unsigned WDOG_W           = 16;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_WAIT_INST = 4'd2,
    ST_EXEC      = 4'd3,
    ST_MEM_REQ   = 4'd4,
    ST_MEM_WAIT  = 4'd5,
    ST_WB        = 4'd6,
    ST_HALT      = 4'd7,
    ST_ERROR     = 4'd8
  } seq_state_e;

  // States that wait on an external handshake and are therefore watchdog-guarded.
  function automatic logic is_handshake(input seq_state_e s);
    case (s)
      ST_FETCH, ST_WAIT_INST, ST_MEM_REQ, ST_MEM_WAIT: is_handshake = 1'b1;
      default:                                         is_handshake = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_sequencer_seq_watchdog.sv
// Handshake watchdog: counts cycles while enabled, flags expiry on the last allowed cycle.
module seq_watchdog
  import exec_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic [WDOG_W-1:0] limit,
  output logic              expire
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && (cnt_q == (limit - WDOG_W'(1)));

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/execute/memory/writeback sequencer gated by valid/ready handshakes.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INST       = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_resp_valid,
  input  logic [31:0] ifu_resp_data,
  output logic [31:0] inst,
  input  logic        is_mem,
  input  logic        rd_wr,
  input  logic        is_ebreak,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_resp_valid,
  output logic        rf_wen,
  output logic        pc_wen,
  output logic        halted,
  output logic        err,
  output logic [63:0] instret
);

  seq_state_e  state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] instret_q, instret_d;
  logic        rd_wr_q, rd_wr_d;
  logic        wd_expire;
  logic        wd_enable;
  logic        wd_clear;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = ST_FETCH;
      ST_FETCH: begin
        if (ifu_req_ready)   state_d = ST_WAIT_INST;
        else if (wd_expire)  state_d = ST_ERROR;
      end
      ST_WAIT_INST: begin
        if (ifu_resp_valid)  state_d = ST_EXEC;
        else if (wd_expire)  state_d = ST_ERROR;
      end
      ST_EXEC: begin
        if (is_ebreak)       state_d = ST_HALT;
        else if (is_mem)     state_d = ST_MEM_REQ;
        else                 state_d = ST_WB;
      end
      ST_MEM_REQ: begin
        if (lsu_req_ready)   state_d = ST_MEM_WAIT;
        else if (wd_expire)  state_d = ST_ERROR;
      end
      ST_MEM_WAIT: begin
        if (lsu_resp_valid)  state_d = ST_WB;
        else if (wd_expire)  state_d = ST_ERROR;
      end
      ST_WB:        state_d = ST_FETCH;
      ST_HALT:      state_d = ST_HALT;
      ST_ERROR:     state_d = ST_ERROR;
      default:      state_d = ST_ERROR;
    endcase
  end

  assign wd_enable = is_handshake(state_q);
  assign wd_clear  = (state_d != state_q);

  seq_watchdog u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .enable (wd_enable),
    .clear  (wd_clear),
    .limit  (WDOG_W'(TIMEOUT_CYCLES)),
    .expire (wd_expire)
  );

  // rd_wr is captured in EXEC so rf_wen in WB stays a pure register decode.
  always_comb begin
    inst_d    = inst_q;
    instret_d = instret_q;
    rd_wr_d   = rd_wr_q;
    if (state_q == ST_WAIT_INST && ifu_resp_valid) inst_d = ifu_resp_data;
    if (state_q == ST_EXEC) rd_wr_d = rd_wr;
    if (state_q == ST_WB) instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      inst_q    <= NOP_INST;
      instret_q <= '0;
      rd_wr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
      rd_wr_q   <= rd_wr_d;
    end
  end

  assign ifu_req_valid = (state_q == ST_FETCH);
  assign lsu_req_valid = (state_q == ST_MEM_REQ);
  assign pc_wen        = (state_q == ST_WB);
  assign rf_wen        = (state_q == ST_WB) && rd_wr_q;
  assign halted        = (state_q == ST_HALT);
  assign err           = (state_q == ST_ERROR);
  assign inst          = inst_q;
  assign instret       = instret_q;

endmodule
